// File: rtl/pipe_stage_if.sv
// Handshake bundle for pipe_stage: upstream valid/ready/data, downstream valid/ready/data,
// flush, occupancy and a debug view of the stage state.
interface pipe_stage_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [1:0]       state_dbg;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, state_dbg
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, state_dbg
    );
endinterface

// File: rtl/pipe_stage.sv
// Single pipeline stage: a 2-entry skid buffer with registered in_ready (SKID=1)
// or a 1-entry register slice with combinational in_ready (SKID=0).
module pipe_stage #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter bit               SKID   = 1'b1
) (
    input logic        clk,
    input logic        rst,
    pipe_stage_if.slave bus
);

    // Handshake: a transfer happens on a port exactly when its valid and ready are both 1 at a
    // rising clk edge; valid never depends on ready, and flush forces in_ready low that cycle.

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] in_data;
    logic             acc;
    logic             dep;

    assign flush     = bus.flush;
    assign in_valid  = bus.in_valid;
    assign out_ready = bus.out_ready;
    assign in_data   = bus.in_data;
    assign acc       = in_valid & bus.in_ready;
    assign dep       = bus.out_valid & out_ready;

    if (SKID) begin : g_skid
        state_e           state_q, state_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             main_en;
        logic             skid_en;
        logic             rdy_q;

        always_comb begin
            state_d = state_q;
            main_en = 1'b0;
            skid_en = 1'b0;
            main_d  = (state_q == ST_TWO) ? skid_q : in_data;
            skid_d  = in_data;
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d = ST_ONE;
                        main_en = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (acc && dep) begin
                        main_en = 1'b1;
                    end else if (acc) begin
                        state_d = ST_TWO;
                        skid_en = 1'b1;
                    end else if (dep) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (dep) begin
                        state_d = ST_ONE;
                        main_en = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
            // Flush wins over everything; a departure in the same cycle still happened downstream.
            if (flush) begin
                state_d = ST_EMPTY;
                main_en = 1'b0;
                skid_en = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_EMPTY;
                rdy_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                rdy_q   <= (state_d != ST_TWO);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                if (main_en) main_q <= main_d;
                if (skid_en) skid_q <= skid_d;
            end
        end

        // rdy_q is low during reset, so no extra reset gating is needed here.
        assign bus.in_ready  = rdy_q & ~flush;
        assign bus.out_valid = (state_q != ST_EMPTY);
        assign bus.out_data  = (state_q != ST_EMPTY) ? main_q : BUBBLE;
        assign bus.occupancy = state_q;
        assign bus.state_dbg = state_q;
    end else begin : g_slice
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] data_q;

        always_comb begin
            valid_d = valid_q;
            if (flush)    valid_d = 1'b0;
            else if (acc) valid_d = 1'b1;
            else if (dep) valid_d = 1'b0;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                if (acc) data_q <= in_data;
            end
        end

        assign bus.in_ready  = ~rst & ~flush & (out_ready | ~valid_q);
        assign bus.out_valid = valid_q;
        assign bus.out_data  = valid_q ? data_q : BUBBLE;
        assign bus.occupancy = {1'b0, valid_q};
        assign bus.state_dbg = valid_q ? ST_ONE : ST_EMPTY;
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: directed vector tables for both SKID settings, a mid-operation
// reset sequence, and a random valid/ready/flush run checked against a reference queue.
module tb_pipe_stage;

  localparam int W = 32;
  localparam logic [W-1:0] BUB = 32'hDEAD_BEEF;

  typedef struct {
    logic         fl;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         rdy;
    logic         ov;
    logic [W-1:0] od;
    logic [1:0]   occ;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp0_q[$];

  vec_t t1[18];
  vec_t t0[8];

  pipe_stage_if #(.WIDTH(W)) b1 ();
  pipe_stage_if #(.WIDTH(W)) b0 ();

  pipe_stage #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b1)) u_skid (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  pipe_stage #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b0)) u_slice (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int sel, input logic fl, input logic iv, input logic [W-1:0] d,
                       input logic ordy);
    if (sel == 1) begin
      b1.flush = fl; b1.in_valid = iv; b1.in_data = d; b1.out_ready = ordy;
    end else begin
      b0.flush = fl; b0.in_valid = iv; b0.in_data = d; b0.out_ready = ordy;
    end
  endtask

  task automatic run_vec(input int sel, input int idx, input vec_t v);
    string tag;
    tag = $sformatf("skid%0d_v%0d", sel, idx);
    @(negedge clk);
    drive(sel, v.fl, v.iv, v.d, v.ordy);
    #1;
    chk({tag, "_in_ready"}, 64'((sel == 1) ? b1.in_ready : b0.in_ready), 64'(v.rdy));
    @(posedge clk);
    #1;
    chk({tag, "_out_valid"}, 64'((sel == 1) ? b1.out_valid : b0.out_valid), 64'(v.ov));
    chk({tag, "_out_data"}, 64'((sel == 1) ? b1.out_data : b0.out_data), 64'(v.od));
    chk({tag, "_occupancy"}, 64'((sel == 1) ? b1.occupancy : b0.occupancy), 64'(v.occ));
  endtask

  // scoreboard step for one DUT, evaluated just before the rising edge
  task automatic score(input int sel);
    logic         fl, iv, ordy, rdy, ov, acc, dep, exp_rdy;
    logic [W-1:0] d, od;
    logic [1:0]   occ;
    int           sz;
    string        tag;
    tag = (sel == 1) ? "rnd_skid1" : "rnd_skid0";
    if (sel == 1) begin
      fl = b1.flush; iv = b1.in_valid; d = b1.in_data; ordy = b1.out_ready;
      rdy = b1.in_ready; ov = b1.out_valid; od = b1.out_data; occ = b1.occupancy;
      sz = exp1_q.size();
      exp_rdy = !fl && (sz < 2);
    end else begin
      fl = b0.flush; iv = b0.in_valid; d = b0.in_data; ordy = b0.out_ready;
      rdy = b0.in_ready; ov = b0.out_valid; od = b0.out_data; occ = b0.occupancy;
      sz = exp0_q.size();
      exp_rdy = !fl && (ordy || sz == 0);
    end
    chk({tag, "_in_ready"}, 64'(rdy), 64'(exp_rdy));
    chk({tag, "_out_valid"}, 64'(ov), 64'(sz != 0));
    chk({tag, "_occupancy"}, 64'(occ), 64'(sz));
    if (sz != 0)
      chk({tag, "_out_data"}, 64'(od), 64'((sel == 1) ? exp1_q[0] : exp0_q[0]));
    else
      chk({tag, "_bubble"}, 64'(od), 64'(BUB));
    acc = iv && exp_rdy;
    dep = (sz != 0) && ordy;
    if (sel == 1) begin
      if (dep) void'(exp1_q.pop_front());
      if (fl) exp1_q.delete();
      else if (acc) exp1_q.push_back(d);
    end else begin
      if (dep) void'(exp0_q.pop_front());
      if (fl) exp0_q.delete();
      else if (acc) exp0_q.push_back(d);
    end
  endtask

  initial begin
    // SKID=1 vectors: {flush, in_valid, in_data, out_ready} -> {in_ready, out_valid, out_data, occ}
    t1[0]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11, 2'd1};
    t1[1]  = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1};
    t1[2]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33, 2'd1};
    t1[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, BUB,    2'd0};
    t1[4]  = '{1'b0, 1'b1, 32'hA0, 1'b0, 1'b1, 1'b1, 32'hA0, 2'd1};
    t1[5]  = '{1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA0, 2'd2};
    t1[6]  = '{1'b0, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA0, 2'd2};
    t1[7]  = '{1'b0, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA0, 2'd2};
    t1[8]  = '{1'b0, 1'b1, 32'hA2, 1'b1, 1'b0, 1'b1, 32'hA1, 2'd1};
    t1[9]  = '{1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 32'hA2, 2'd1};
    t1[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, BUB,    2'd0};
    t1[11] = '{1'b0, 1'b1, 32'hB0, 1'b0, 1'b1, 1'b1, 32'hB0, 2'd1};
    t1[12] = '{1'b0, 1'b1, 32'hB1, 1'b0, 1'b1, 1'b1, 32'hB0, 2'd2};
    t1[13] = '{1'b1, 1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, BUB,    2'd0};
    t1[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, BUB,    2'd0};
    t1[15] = '{1'b0, 1'b1, 32'hC0, 1'b0, 1'b1, 1'b1, 32'hC0, 2'd1};
    t1[16] = '{1'b1, 1'b1, 32'hC1, 1'b1, 1'b0, 1'b0, BUB,    2'd0};
    t1[17] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, BUB,    2'd0};
    // SKID=0 vectors
    t0[0]  = '{1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11, 2'd1};
    t0[1]  = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1};
    t0[2]  = '{1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h22, 2'd1};
    t0[3]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33, 2'd1};
    t0[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, BUB,    2'd0};
    t0[5]  = '{1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 32'h44, 2'd1};
    t0[6]  = '{1'b1, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0, BUB,    2'd0};
    t0[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, BUB,    2'd0};

    drive(1, 1'b0, 1'b0, '0, 1'b0);
    drive(0, 1'b0, 1'b0, '0, 1'b0);

    // reset state
    #2;
    chk("rst_skid1_out_valid", 64'(b1.out_valid), 64'(1'b0));
    chk("rst_skid1_out_data", 64'(b1.out_data), 64'(BUB));
    chk("rst_skid1_occupancy", 64'(b1.occupancy), 64'd0);
    chk("rst_skid1_in_ready", 64'(b1.in_ready), 64'(1'b0));
    chk("rst_skid0_in_ready", 64'(b0.in_ready), 64'(1'b0));
    chk("rst_skid0_out_data", 64'(b0.out_data), 64'(BUB));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_skid1_in_ready_before_edge", 64'(b1.in_ready), 64'(1'b0));
    chk("rel_skid0_in_ready", 64'(b0.in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    chk("rel_skid1_in_ready_after_edge", 64'(b1.in_ready), 64'(1'b1));

    for (int i = 0; i < 18; i++) run_vec(1, i, t1[i]);
    for (int i = 0; i < 8; i++) run_vec(0, i, t0[i]);

    // asynchronous reset between edges with two entries held
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 32'hD0, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 32'hD1, 1'b0);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("mid_pre_occupancy", 64'(b1.occupancy), 64'd2);
    chk("mid_pre_out_data", 64'(b1.out_data), 64'h0000_0000_0000_00D0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(b1.out_valid), 64'(1'b0));
    chk("mid_rst_out_data", 64'(b1.out_data), 64'(BUB));
    chk("mid_rst_occupancy", 64'(b1.occupancy), 64'd0);
    chk("mid_rst_in_ready", 64'(b1.in_ready), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready_before_edge", 64'(b1.in_ready), 64'(1'b0));
    @(posedge clk);
    #1;
    chk("mid_rel_in_ready_after_edge", 64'(b1.in_ready), 64'(1'b1));
    chk("mid_rel_out_valid", 64'(b1.out_valid), 64'(1'b0));

    // random traffic on both stages against the reference queues
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      drive(1, ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), $urandom(),
            ($urandom_range(0, 3) != 0));
      drive(0, ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 1)));
      #1;
      score(1);
      score(0);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits; legal range 1..512.
REQ-002 Parameter BUBBLE, default '0 (WIDTH bits): value driven on out_data whenever out_valid is 0.
REQ-003 Parameter SKID, default 1: 1 gives a 2-entry skid stage with registered in_ready; 0 gives a 1-entry stage with combinational in_ready.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 flush  input  1  discards all held entries at the next rising edge.
REQ-007 in_valid  input  1  upstream presents in_data.
REQ-008 in_ready  output  1  stage accepts in_data this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 out_data  output  WIDTH  payload to downstream, or BUBBLE when not valid.
REQ-013 occupancy  output  2  number of held entries: 0..2 when SKID=1, 0..1 when SKID=0.

Function
REQ-014 A transfer SHALL occur on an input when valid and ready are both 1 at a rising edge; the same rule applies on the output.
REQ-015 Latency SHALL be 1 cycle: a payload accepted at edge N SHALL appear on out_data with out_valid=1 after edge N, provided the stage was empty.
REQ-016 Entries SHALL leave in strict acceptance order; no payload SHALL be duplicated or lost except by flush.
REQ-017 With SKID=1, the stage SHALL hold a main register (driving out_*) and a skid register, and SHALL have three states:
  - EMPTY: occupancy 0.
  - ONE: main valid, occupancy 1.
  - TWO: main and skid valid, occupancy 2.
REQ-018 SKID=1 transitions (acc = input transfer, dep = output transfer):
  - EMPTY + acc -> ONE.
  - ONE + acc + dep -> ONE, with main loaded from in_data.
  - ONE + acc + !dep -> TWO, with skid loaded.
  - ONE + !acc + dep -> EMPTY.
  - TWO + dep -> ONE, with main loaded from skid.
  - In every other case the state SHALL be held.
REQ-019 With SKID=1, in_ready SHALL be a registered signal equal to 1 exactly when the state is not TWO; it SHALL have no combinational path from out_ready.
REQ-020 With SKID=1, sustained in_valid=1 and out_ready=1 SHALL give 1 transfer per cycle.
REQ-021 With SKID=0, in_ready SHALL equal (out_ready OR NOT out_valid) combinationally, and the single register SHALL load whenever an input transfer occurs.
REQ-022 out_data SHALL equal BUBBLE whenever out_valid=0, including after a flush or a drain.
REQ-023 When flush=1, in_ready SHALL be 0 in the same cycle, and at the next edge the stage SHALL go to EMPTY with occupancy 0; flush SHALL take priority over acceptance and over departure.
REQ-024 Flush in the same cycle as out_ready=1 SHALL still count as an output transfer of the current head; the downstream owns that decision.
REQ-025 in_data and out_data SHALL NOT be sampled or updated when no transfer occurs; held payloads SHALL stay bit-stable while out_ready=0.
REQ-026 occupancy SHALL never exceed 2 (SKID=1) or 1 (SKID=0); an input transfer while full SHALL be impossible by construction.

Reset
REQ-027 While rst=1, asynchronously: out_valid=0, out_data=BUBBLE, occupancy=0, state EMPTY, in_ready=0.
REQ-028 At the first clk edge after rst falls, in_ready SHALL become 1 (SKID=1); with SKID=0 it follows REQ-021 immediately.
REQ-029 rst asserted mid-operation SHALL discard all held entries without an output transfer, regardless of clock state.

Verification
REQ-030 SKID=1, WIDTH=32: send 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data shows 0x11, 0x22, 0x33 on the next three cycles; occupancy stays 1.
REQ-031 SKID=1: hold out_ready=0 and offer 0xA0, 0xA1, 0xA2 -> 0xA0 and 0xA1 accepted, occupancy=2, in_ready=0, 0xA2 held upstream; release out_ready -> order 0xA0, 0xA1, 0xA2 with no loss.
REQ-032 Flush while occupancy=2 with in_valid=1 -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0, and the offered input is not accepted.
REQ-033 SKID=0: out_valid=1, out_ready=0 -> in_ready=0; raise out_ready in the same cycle -> in_ready=1 combinationally and the entry is replaced at the edge.
REQ-034 Assert rst between edges at occupancy=2 -> out_valid=0 and out_data=BUBBLE immediately; after release, in_ready=1 at the first edge.
REQ-035 Random valid/ready with a scoreboard for 10^5 cycles, both SKID values -> order preserved, zero loss, occupancy bound always holds.
